dec_scan_ctrl: RTL and testbench

Digit-scan sequencer that directly feeds the 3-to-8 decoders (dec3to8_shift / dec3to8_case). It produces the registered {en, in[2:0]} pair and steps through the enabled digit indices at a programmable rate. A blanking gap is inserted between digits to suppress ghosting. The decoder's one-hot output then drives the digit-select lines of a multiplexed 8-digit display.

---
 rtl/dec_scan_ctrl_if.sv | 27 ++
 rtl/dec_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_dec_scan_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dec_scan_ctrl_if.sv
// Digit-scan control bus: run/mask requests in, registered decoder select/enable and step pulses out.
interface dec_scan_ctrl_if;
    logic       i_run;
    logic [7:0] i_mask;
    logic [2:0] o_in;
    logic       o_en;
    logic       o_tick;
    logic       o_wrap;

    modport slave (
        input  i_run,
        input  i_mask,
        output o_in,
        output o_en,
        output o_tick,
        output o_wrap
    );

    modport master (
        output i_run,
        output i_mask,
        input  o_in,
        input  o_en,
        input  o_tick,
        input  o_wrap
    );
endinterface

// File: rtl/dec_scan_ctrl.sv
// Digit-scan sequencer for a 3-to-8 decoder: steps through enabled indices with a
// programmable drive time per digit and an optional blanking gap before each slot.
module dec_scan_ctrl #(
    parameter int unsigned DIV       = 4,
    parameter int unsigned BLANK     = 1,
    parameter int unsigned NUM_DIGIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    dec_scan_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam int unsigned CNT_MAX    = (DIV > BLANK) ? DIV : BLANK;
    localparam int unsigned CW         = $clog2(CNT_MAX + 1);
    localparam int unsigned DIV_LAST   = DIV - 1;
    localparam int unsigned BLANK_LAST = (BLANK == 0) ? 0 : BLANK - 1;
    localparam logic [7:0]  DIGIT_MASK = 8'((9'(1) << NUM_DIGIT) - 9'(1));
    // Every slot begins in the gap unless blanking is disabled.
    localparam state_t      SLOT_START = (BLANK == 0) ? DRIVE : GAP;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      in_q, in_d;
    logic            en_q, en_d;
    logic            tick_q, tick_d;
    logic            wrap_q, wrap_d;

    logic [7:0]      em_c;
    logic            any_c;
    logic            low_found_c;
    logic [2:0]      low_idx_c;
    logic            nxt_found_c;
    logic [2:0]      nxt_idx_c;

    // Effective mask, lowest enabled index, and next enabled index above o_in (wrapping).
    always_comb begin
        em_c        = bus.i_mask & DIGIT_MASK;
        any_c       = |em_c;
        low_found_c = 1'b0;
        low_idx_c   = '0;
        nxt_found_c = 1'b0;
        nxt_idx_c   = in_q;
        for (int unsigned k = 0; k < NUM_DIGIT; k++) begin
            if (!low_found_c && em_c[3'(k)]) begin
                low_found_c = 1'b1;
                low_idx_c   = 3'(k);
            end
        end
        for (int unsigned k = 1; k <= NUM_DIGIT; k++) begin
            if (!nxt_found_c && em_c[3'((32'(in_q) + k) % NUM_DIGIT)]) begin
                nxt_found_c = 1'b1;
                nxt_idx_c   = 3'((32'(in_q) + k) % NUM_DIGIT);
            end
        end
    end

    // Next-state and output logic; a stop request always wins over an advance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        in_d    = in_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        en_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.i_run && any_c) begin
                    in_d    = low_idx_c;
                    cnt_d   = '0;
                    state_d = SLOT_START;
                end
            end
            GAP: begin
                if (!bus.i_run) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(BLANK_LAST)) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRIVE: begin
                if (!bus.i_run) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(DIV_LAST)) begin
                    cnt_d = '0;
                    if (!any_c) begin
                        state_d = IDLE;
                    end else begin
                        in_d    = nxt_idx_c;
                        tick_d  = 1'b1;
                        wrap_d  = (nxt_idx_c <= in_q);
                        state_d = SLOT_START;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        en_d = (state_d == DRIVE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            in_q    <= '0;
            en_q    <= 1'b0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            in_q    <= in_d;
            en_q    <= en_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.o_in   = in_q;
    assign bus.o_en   = en_q;
    assign bus.o_tick = tick_q;
    assign bus.o_wrap = wrap_q;

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Self-checking bench for dec_scan_ctrl: vector table, directed corner sequences and
// randomized run/mask stimulus compared against a slot-level reference model.
module tb_dec_scan_ctrl;

    logic clk;
    logic rst;

    dec_scan_ctrl_if ifa ();
    dec_scan_ctrl_if ifb ();

    dec_scan_ctrl #(.DIV(4), .BLANK(1), .NUM_DIGIT(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    dec_scan_ctrl #(.DIV(2), .BLANK(0), .NUM_DIGIT(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Slot-level model: position within the current slot plus the index being shown.
    typedef struct {
        bit act;
        int pos;
        int idx;
        bit en;
        bit tick;
        bit wrap;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mreset();
        mdl_t m;
        m.act = 0; m.pos = 0; m.idx = 0; m.en = 0; m.tick = 0; m.wrap = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m_in, bit run, logic [7:0] mask,
                                   int blank, int div, int nd);
        mdl_t m;
        int   q[$];
        int   nxt;
        bit   found;
        m = m_in;
        for (int k = 0; k < nd; k++) if (mask[k]) q.push_back(k);
        m.tick = 0;
        m.wrap = 0;
        if (!m.act) begin
            if (run && q.size() > 0) begin
                m.act = 1;
                m.pos = 0;
                m.idx = q[0];
            end
        end else if (!run) begin
            m.act = 0;
        end else begin
            m.pos++;
            if (m.pos == blank + div) begin
                if (q.size() == 0) begin
                    m.act = 0;
                end else begin
                    nxt   = q[0];
                    found = 0;
                    for (int j = 0; j < q.size(); j++) begin
                        if (!found && q[j] > m.idx) begin
                            nxt   = q[j];
                            found = 1;
                        end
                    end
                    m.tick = 1;
                    m.wrap = (nxt <= m.idx);
                    m.idx  = nxt;
                    m.pos  = 0;
                end
            end
        end
        m.en = m.act && (m.pos >= blank);
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cmp_model();
        chk("a_in",   32'(ifa.o_in),   32'(ma.idx));
        chk("a_en",   32'(ifa.o_en),   32'(ma.en));
        chk("a_tick", 32'(ifa.o_tick), 32'(ma.tick));
        chk("a_wrap", 32'(ifa.o_wrap), 32'(ma.wrap));
        chk("b_in",   32'(ifb.o_in),   32'(mb.idx));
        chk("b_en",   32'(ifb.o_en),   32'(mb.en));
        chk("b_tick", 32'(ifb.o_tick), 32'(mb.tick));
        chk("b_wrap", 32'(ifb.o_wrap), 32'(mb.wrap));
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_a"}, {26'd0, ifa.o_in, ifa.o_en, ifa.o_tick, ifa.o_wrap}, 32'd0);
        chk({name, "_b"}, {26'd0, ifb.o_in, ifb.o_en, ifb.o_tick, ifb.o_wrap}, 32'd0);
    endtask

    // One clock: step both models on the inputs held across the edge, then compare.
    task automatic cycle();
        @(posedge clk);
        ma = mstep(ma, ifa.i_run, ifa.i_mask, 1, 4, 8);
        mb = mstep(mb, ifb.i_run, ifb.i_mask, 0, 2, 4);
        #1;
        cmp_model();
    endtask

    task automatic do_reset();
        ifa.i_run = 0; ifa.i_mask = 8'h00;
        ifb.i_run = 0; ifb.i_mask = 8'h00;
        @(posedge clk);
        #2;
        rst = 1;
        ma = mreset();
        mb = mreset();
        #1;
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    typedef struct {
        bit         run;
        logic [7:0] mask;
        logic [2:0] in;
        bit         en;
        bit         tick;
        bit         wrap;
    } vec_t;

    vec_t tbl[19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int ticks;
        int wraps;

        // Mask 1010_0100 from reset: 2 -> 5 -> 7 -> 2 (wrap), then stop.
        tbl[0]  = '{1, 8'hA4, 3'd2, 0, 0, 0};
        for (int i = 1; i <= 4; i++)   tbl[i] = '{1, 8'hA4, 3'd2, 1, 0, 0};
        tbl[5]  = '{1, 8'hA4, 3'd5, 0, 1, 0};
        for (int i = 6; i <= 9; i++)   tbl[i] = '{1, 8'hA4, 3'd5, 1, 0, 0};
        tbl[10] = '{1, 8'hA4, 3'd7, 0, 1, 0};
        for (int i = 11; i <= 14; i++) tbl[i] = '{1, 8'hA4, 3'd7, 1, 0, 0};
        tbl[15] = '{1, 8'hA4, 3'd2, 0, 1, 1};
        tbl[16] = '{1, 8'hA4, 3'd2, 1, 0, 0};
        tbl[17] = '{0, 8'hA4, 3'd2, 0, 0, 0};
        tbl[18] = '{0, 8'hA4, 3'd2, 0, 0, 0};

        rst = 1;
        ifa.i_run = 0; ifa.i_mask = 8'h00;
        ifb.i_run = 0; ifb.i_mask = 8'h00;
        ma = mreset();
        mb = mreset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset_state");
        rst = 0;

        for (int i = 0; i < 19; i++) begin
            ifa.i_run  = tbl[i].run;
            ifa.i_mask = tbl[i].mask;
            cycle();
            chk($sformatf("tbl%0d_in", i),   32'(ifa.o_in),   32'(tbl[i].in));
            chk($sformatf("tbl%0d_en", i),   32'(ifa.o_en),   32'(tbl[i].en));
            chk($sformatf("tbl%0d_tick", i), 32'(ifa.o_tick), 32'(tbl[i].tick));
            chk($sformatf("tbl%0d_wrap", i), 32'(ifa.o_wrap), 32'(tbl[i].wrap));
        end

        // Full mask: 16 steps over 81 cycles, wrapping on each 7->0.
        do_reset();
        ifa.i_run = 1; ifa.i_mask = 8'hFF;
        ticks = 0; wraps = 0;
        for (int c = 0; c < 81; c++) begin
            cycle();
            ticks += int'(ifa.o_tick);
            wraps += int'(ifa.o_wrap);
            if (ifa.o_wrap) chk("ff_wrap_to_0", 32'(ifa.o_in), 32'd0);
        end
        chk("ff_ticks", 32'(ticks), 32'd16);
        chk("ff_wraps", 32'(wraps), 32'd2);

        // Single enabled digit: index stays put, tick and wrap every slot.
        do_reset();
        ifa.i_run = 1; ifa.i_mask = 8'h10;
        ticks = 0; wraps = 0;
        for (int c = 0; c < 30; c++) begin
            cycle();
            chk("single_in", 32'(ifa.o_in), 32'd4);
            ticks += int'(ifa.o_tick);
            wraps += int'(ifa.o_wrap);
        end
        chk("single_ticks", 32'(ticks), 32'd5);
        chk("single_wraps", 32'(wraps), 32'd5);

        // Stop mid-DRIVE of index 3, then restart from the lowest index.
        do_reset();
        ifa.i_run = 1; ifa.i_mask = 8'hFF;
        guard = 0;
        while (!(ifa.o_in == 3'd3 && ifa.o_en) && guard < 100) begin
            cycle();
            guard++;
        end
        chk("reach_idx3", 32'(guard < 100), 32'd1);
        cycle();
        ifa.i_run = 0;
        cycle();
        chk("stop_en",   32'(ifa.o_en),   32'd0);
        chk("stop_in",   32'(ifa.o_in),   32'd3);
        chk("stop_tick", 32'(ifa.o_tick), 32'd0);
        cycle();
        cycle();
        ifa.i_run = 1; ifa.i_mask = 8'hFF;
        cycle();
        chk("restart_in", 32'(ifa.o_in), 32'd0);
        chk("restart_gap", 32'(ifa.o_en), 32'd0);
        cycle();
        chk("restart_en", 32'(ifa.o_en), 32'd1);

        // Asynchronous reset between clock edges, mid-slot.
        do_reset();
        ifa.i_run = 1; ifa.i_mask = 8'hFF;
        ifb.i_run = 1; ifb.i_mask = 8'h0F;
        for (int c = 0; c < 13; c++) cycle();
        #2;
        rst = 1;
        ma = mreset();
        mb = mreset();
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #1;
        chk_zero("rst_held");
        ifa.i_run = 0; ifb.i_run = 0;
        rst = 0;
        cycle();
        chk_zero("rst_released_idle");

        // Four-digit instance, no blanking: masked-off bits keep it idle.
        do_reset();
        ifb.i_run = 1; ifb.i_mask = 8'hF0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("b_idle_en", 32'(ifb.o_en), 32'd0);
        end
        ifb.i_mask = 8'h0A;
        for (int c = 0; c < 12; c++) begin
            cycle();
            chk("b_cont_en", 32'(ifb.o_en), 32'd1);
            chk("b_seq_in", 32'(ifb.o_in), ((c / 2) % 2 == 1) ? 32'd3 : 32'd1);
        end

        // Randomized run/mask traffic on both instances.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            ifa.i_run = ($urandom_range(0, 15) != 0);
            ifb.i_run = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0)
                ifa.i_mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 7) == 0)
                ifb.i_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15) << 4)
                                                         : 8'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
